// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor. The carry chain is cut into STAGES equal
// slices, one slice resolved per pipeline stage. Operands not yet consumed
// and sum bits already produced ride along so a whole op exits together.
// Valid/ready flow control stalls the entire pipe as one unit.

// One slice of the carry chain: plain ripple add of SW bits plus carry-in.
module pipe_addsub_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout
);
  logic [SW:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
  assign sum  = full[SW-1:0];
  assign cout = full[SW];
endmodule

module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int SW = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("pipe_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d), STAGES >= 1",
           WIDTH, STAGES);
  end

  // Stage k holds the op after slices 0..k-1 have been resolved.
  // Stage STAGES is the output register.
  logic              adv;
  logic [STAGES:0]   vld_pipe;
  logic [WIDTH-1:0]  a_pipe   [0:STAGES-1];
  logic [WIDTH-1:0]  b_pipe   [0:STAGES-1];
  logic [WIDTH-1:0]  sum_pipe [1:STAGES];
  logic              c_pipe   [0:STAGES];

  // Whole pipe moves when the output slot is empty or being drained.
  assign adv       = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_sum   = sum_pipe[STAGES];
  assign out_cout  = c_pipe[STAGES];

  // Valid bits shift with the data; idle input cycles become bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
  end

  // Stage 0 capture: subtraction folds into A + ~B + 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_pipe[0] <= '0;
      b_pipe[0] <= '0;
      c_pipe[0] <= 1'b0;
    end else if (adv) begin
      a_pipe[0] <= in_a;
      b_pipe[0] <= in_sub ? ~in_b : in_b;
      c_pipe[0] <= in_sub | in_cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nxt;
    logic [SW-1:0]    ss;
    logic             co;

    pipe_addsub_slice #(.SW(SW)) u_slice (
      .a    (a_pipe[k][k*SW +: SW]),
      .b    (b_pipe[k][k*SW +: SW]),
      .cin  (c_pipe[k]),
      .sum  (ss),
      .cout (co)
    );

    if (k == 0) begin : g_base0
      assign base = '0;
    end else begin : g_basen
      assign base = sum_pipe[k];
    end

    // Merge this slice's result into the partial sum carried so far.
    always_comb begin
      nxt            = base;
      nxt[k*SW +: SW] = ss;
    end

    // Register partial sum and slice carry into the next stage.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_pipe[k+1] <= '0;
        c_pipe[k+1]   <= 1'b0;
      end else if (adv) begin
        sum_pipe[k+1] <= nxt;
        c_pipe[k+1]   <= co;
      end
    end

    if (k + 1 < STAGES) begin : g_fwd
      // Operands travel with the op until their slice is consumed.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_pipe[k+1] <= '0;
          b_pipe[k+1] <= '0;
        end else if (adv) begin
          a_pipe[k+1] <= a_pipe[k];
          b_pipe[k+1] <= b_pipe[k];
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      // Carry into the MSB recovered as a^b^sum at that bit; ovf = cin_msb ^ cout.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_ovf  <= 1'b0;
          out_zero <= 1'b0;
        end else if (adv) begin
          out_ovf  <= a_pipe[k][WIDTH-1] ^ b_pipe[k][WIDTH-1] ^ nxt[WIDTH-1] ^ co;
          out_zero <= ~|nxt;
        end
      end
    end
  end
endmodule
